// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences the shared MAC datapath and truncation stage
// through `layers` layers, feeding truncated activations back as input.
// Ports: clk, rst_vals (async, active-high); start/in_vec begin an inference;
//   compute_start/compute_done handshake with the MAC datapath;
//   layer_done/trunc_done/layer_out_trunc handshake with truncation;
//   layer_idx, layer_in expose the current layer; vals_clr clears the
//   accumulators between layers; result/result_valid present the final
//   vector; busy is high outside IDLE; timeout_err is a sticky watchdog flag.
// Optional: define LAYER_SCHED_TIMEOUT_EN for a per-wait-state watchdog.
module layer_scheduler #(
    parameter int layers         = 2,
    parameter int row            = 30,
    parameter int datawidth      = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_vals,
    input  logic                                 start,
    input  logic [row*datawidth-1:0]             in_vec,
    output logic                                 compute_start,
    input  logic                                 compute_done,
    output logic [(layers > 1 ? $clog2(layers) : 1)-1:0] layer_idx,
    output logic [row*datawidth-1:0]             layer_in,
    output logic                                 layer_done,
    input  logic                                 trunc_done,
    input  logic [row*datawidth-1:0]             layer_out_trunc,
    output logic                                 vals_clr,
    output logic [row*datawidth-1:0]             result,
    output logic                                 result_valid,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int IDXW = (layers > 1) ? $clog2(layers) : 1;
    localparam int VW   = row * datawidth;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MAC,
        WAIT_TRUNC,
        DRAIN,
        NEXT,
        FINISH
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [VW-1:0]   act_reg;
    logic            last_layer;
    logic            tmo;

    assign last_layer = (layer_idx == IDXW'(layers - 1));
    assign layer_in   = act_reg;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        compute_start = 1'b0;
        vals_clr      = 1'b0;
        result_valid  = 1'b0;
        case (state_q)
            IDLE:       if (start) state_d = ISSUE;
            ISSUE: begin
                compute_start = 1'b1;
                state_d       = WAIT_MAC;
            end
            WAIT_MAC:   if (compute_done) state_d = WAIT_TRUNC;
            WAIT_TRUNC: if (trunc_done) state_d = DRAIN;
            // Hold until truncation is idle again so it cannot
            // misread the next layer_done edge.
            DRAIN: begin
                if (!trunc_done)
                    state_d = last_layer ? FINISH : NEXT;
            end
            NEXT: begin
                vals_clr = 1'b1;
                state_d  = ISSUE;
            end
            FINISH: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default:    state_d = IDLE;
        endcase
        if (tmo) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst_vals) begin
        if (rst_vals) begin
            state_q    <= IDLE;
            act_reg    <= '0;
            result     <= '0;
            layer_idx  <= '0;
            layer_done <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        act_reg   <= in_vec;
                        layer_idx <= '0;
                    end
                end
                WAIT_MAC: begin
                    if (compute_done) layer_done <= 1'b1;
                end
                WAIT_TRUNC: begin
                    if (trunc_done) begin
                        act_reg    <= layer_out_trunc;
                        layer_done <= 1'b0;
                    end
                end
                NEXT:    layer_idx <= layer_idx + IDXW'(1);
                FINISH:  result <= act_reg;
                default: ;
            endcase
            // Watchdog abort wins over a same-cycle compute_done.
            if (tmo) layer_done <= 1'b0;
        end
    end

`ifdef LAYER_SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNTW-1:0] wait_cnt;
    logic            in_wait;
    logic            err_q;

    assign in_wait = (state_q == WAIT_MAC) ||
                     (state_q == WAIT_TRUNC) ||
                     (state_q == DRAIN);
    // wait_cnt is 0 on the first cycle in a wait state, so the
    // limit is hit on the TIMEOUT_CYCLES-th cycle spent there.
    assign tmo = in_wait &&
                 (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk or posedge rst_vals) begin
        if (rst_vals) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: self-checking bench for layer_scheduler with MAC and
// truncation models, a result scoreboard and a layers=1 second instance.
module tb_layer_scheduler;

    localparam int ROW = 4;
    localparam int DW  = 11;
    localparam int W   = ROW * DW;

    logic         clk = 1'b0;
    logic         rst_vals = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in_vec = '0;
    logic         compute_done = 1'b0;
    logic         trunc_done = 1'b0;
    logic [W-1:0] layer_out_trunc = '0;
    logic         compute_start;
    logic [0:0]   layer_idx;
    logic [W-1:0] layer_in;
    logic         layer_done;
    logic         vals_clr;
    logic [W-1:0] result;
    logic         result_valid;
    logic         busy;
    logic         timeout_err;

    logic         s2 = 1'b0;
    logic [W-1:0] in2 = '0;
    logic         cd2 = 1'b0;
    logic         td2 = 1'b0;
    logic [W-1:0] lot2 = '0;
    logic         cs2;
    logic [0:0]   idx2;
    logic [W-1:0] li2;
    logic         ld2;
    logic         vc2;
    logic [W-1:0] res2;
    logic         rv2;
    logic         busy2;
    logic         te2;

    always #5 clk = ~clk;

    layer_scheduler #(
        .layers(2), .row(ROW), .datawidth(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_vals(rst_vals), .start(start), .in_vec(in_vec),
        .compute_start(compute_start), .compute_done(compute_done),
        .layer_idx(layer_idx), .layer_in(layer_in),
        .layer_done(layer_done), .trunc_done(trunc_done),
        .layer_out_trunc(layer_out_trunc), .vals_clr(vals_clr),
        .result(result), .result_valid(result_valid), .busy(busy),
        .timeout_err(timeout_err)
    );

    layer_scheduler #(
        .layers(1), .row(ROW), .datawidth(DW), .TIMEOUT_CYCLES(16)
    ) dut1 (
        .clk(clk), .rst_vals(rst_vals), .start(s2), .in_vec(in2),
        .compute_start(cs2), .compute_done(cd2),
        .layer_idx(idx2), .layer_in(li2),
        .layer_done(ld2), .trunc_done(td2),
        .layer_out_trunc(lot2), .vals_clr(vc2),
        .result(res2), .result_valid(rv2), .busy(busy2),
        .timeout_err(te2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] inc_vec(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < ROW; i++)
            r[i*DW +: DW] = v[i*DW +: DW] + 11'd1;
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit mac_en = 1'b1;
    int trunc_hold = 1;

    // MAC model: compute_done pulse 5 cycles after compute_start.
    initial forever begin
        @(negedge clk);
        if (compute_start && mac_en) begin
            repeat (5) @(negedge clk);
            compute_done = 1'b1;
            @(negedge clk);
            compute_done = 1'b0;
        end
    end

    int fall_cyc[$];

    // Truncation model: output = input + 1 per element after row+1 cycles.
    initial forever begin
        @(negedge clk);
        if (layer_done) begin
            repeat (ROW) @(negedge clk);
            layer_out_trunc = inc_vec(layer_in);
            trunc_done = 1'b1;
            repeat (trunc_hold) @(negedge clk);
            trunc_done = 1'b0;
            fall_cyc.push_back(cyc);
        end
    end

    int cs_cnt = 0, vc_cnt = 0, rv_cnt = 0;
    int cs2_cnt = 0, vc2_cnt = 0;
    int cs_cyc[$];
    int idx_log[$];
    logic [W-1:0] sb[$];
    bit rv_pend = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rv_pend) begin
            rv_pend = 1'b0;
            if (sb.size() == 0)
                chk("sb_unexpected", 1, 0);
            else
                chk("result", result, sb.pop_front());
        end
        if (compute_start) begin
            cs_cnt++;
            cs_cyc.push_back(cyc);
            idx_log.push_back(int'(layer_idx));
        end
        if (vals_clr) vc_cnt++;
        if (result_valid) begin
            rv_cnt++;
            rv_pend = 1'b1;
        end
        if (cs2) cs2_cnt++;
        if (vc2) vc2_cnt++;
    end

    task automatic run_one(input string tag, input logic [W-1:0] v,
                           input logic [W-1:0] e, input bit hold);
        int cs0, vc0, rv0, t;
        cs0 = cs_cnt;
        vc0 = vc_cnt;
        rv0 = rv_cnt;
        cs_cyc.delete();
        idx_log.delete();
        fall_cyc.delete();
        in_vec = v;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk({tag, "_cs_lat"}, compute_start, 1);
        chk({tag, "_busy"}, busy, 1);
        t = 0;
        while (rv_cnt == rv0 && t < 400) begin
            @(negedge clk);
            t++;
            if (hold && t == 10) start = 1'b0;
            if (hold && t == 12) start = 1'b1;
            if (result_valid) start = 1'b0;
        end
        chk({tag, "_no_timeout"}, t < 400, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_n_cs"}, cs_cnt - cs0, 2);
        chk({tag, "_n_clr"}, vc_cnt - vc0, 1);
        chk({tag, "_n_rv"}, rv_cnt - rv0, 1);
        chk({tag, "_idle"}, busy, 0);
        if (idx_log.size() == 2) begin
            chk({tag, "_idx0"}, idx_log[0], 0);
            chk({tag, "_idx1"}, idx_log[1], 1);
        end
        if (cs_cyc.size() >= 2 && fall_cyc.size() >= 1)
            chk({tag, "_gap"}, cs_cyc[1] - fall_cyc[0], 2);
        else
            chk({tag, "_gap_seen"}, 0, 1);
    endtask

    typedef struct {
        logic [W-1:0] in;
        logic [W-1:0] exp;
        bit           hold;
        int           th;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int t, rv0;
        tbl[0] = '{{11'h001, 11'h002, 11'h003, 11'h004},
                   {11'h003, 11'h004, 11'h005, 11'h006}, 1'b0, 1};
        tbl[1] = '{{11'h7FF, 11'h7FE, 11'h000, 11'h400},
                   {11'h001, 11'h000, 11'h002, 11'h402}, 1'b1, 1};
        tbl[2] = '{{11'h3FF, 11'h123, 11'h555, 11'h0AA},
                   {11'h401, 11'h125, 11'h557, 11'h0AC}, 1'b0, 4};
        tbl[3] = '{{11'h000, 11'h000, 11'h000, 11'h000},
                   {11'h002, 11'h002, 11'h002, 11'h002}, 1'b0, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ld", layer_done, 0);
        chk("rst_idx", layer_idx, 0);
        chk("rst_res", result, 0);
        chk("rst_cs", compute_start, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_te", timeout_err, 0);
        rst_vals = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            trunc_hold = tbl[i].th;
            run_one($sformatf("v%0d", i), tbl[i].in, tbl[i].exp,
                    tbl[i].hold);
        end
        trunc_hold = 1;

        // Reset in the second layer's WAIT_TRUNC.
        in_vec = tbl[0].in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(layer_done && layer_idx == 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reach", t < 200, 1);
        rv0 = rv_cnt;
        rst_vals = 1'b1;
        #1;
        chk("rst_mid_ld", layer_done, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_idx", layer_idx, 0);
        @(negedge clk);
        rst_vals = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_rv", rv_cnt - rv0, 0);
        chk("rst_mid_res", result, 0);
        run_one("post_rst", tbl[2].in, tbl[2].exp, 1'b0);

        // layers=1 instance: no NEXT, result one cycle after DRAIN.
        in2 = tbl[2].in;
        s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        chk("l1_cs", cs2, 1);
        chk("l1_lin", li2, tbl[2].in);
        repeat (3) @(negedge clk);
        cd2 = 1'b1;
        @(negedge clk);
        cd2 = 1'b0;
        chk("l1_ld", ld2, 1);
        lot2 = inc_vec(in2);
        td2 = 1'b1;
        @(negedge clk);
        td2 = 1'b0;
        chk("l1_ld_fall", ld2, 0);
        @(negedge clk);
        chk("l1_rv", rv2, 1);
        @(negedge clk);
        chk("l1_rv_pulse", rv2, 0);
        chk("l1_res", res2, inc_vec(tbl[2].in));
        chk("l1_idle", busy2, 0);
        chk("l1_n_cs", cs2_cnt, 1);
        chk("l1_n_clr", vc2_cnt, 0);

`ifdef LAYER_SCHED_TIMEOUT_EN
        mac_en = 1'b0;
        rv0 = rv_cnt;
        in_vec = tbl[0].in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("tmo_early", timeout_err, 0);
        repeat (10) @(negedge clk);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_rv", rv_cnt - rv0, 0);
        repeat (10) @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);
        rst_vals = 1'b1;
        @(negedge clk);
        rst_vals = 1'b0;
        chk("tmo_clr", timeout_err, 0);
        mac_en = 1'b1;
`else
        chk("te_tied", timeout_err, 0);
        chk("te2_tied", te2, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Top-level sequencer for block inference.
- Drives one shared MAC layer datapath and the downstream truncation stage through `layers` consecutive layers.
- After each layer, feeds the truncated activations back as the next layer's input.
- Presents the final-layer vector with a valid pulse; owns all inter-layer handshakes and per-layer value clears.

Parameters:
- layers, 2, number of layers to sequence (>=1)
- row, 30, neurons per layer / elements per activation vector
- datawidth, 11, bits per activation element (signed fixed point)
- TIMEOUT_CYCLES, 4096, watchdog limit per wait state (used only with TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_vals  in  1  asynchronous active-high reset
- start  in  1  begin inference; sampled only in IDLE
- in_vec  in  row*datawidth  first-layer input vector, captured on accepted start
- compute_start  out  1  one-cycle pulse: MAC datapath begins current layer
- compute_done  in  1  MAC datapath finished current layer (level or pulse)
- layer_idx  out  max(1,$clog2(layers))  index of layer in progress
- layer_in  out  row*datawidth  activation vector for current layer (act_reg)
- layer_done  out  1  level to truncation; high from MAC finish until trunc_done seen
- trunc_done  in  1  truncation complete
- layer_out_trunc  in  row*datawidth  truncated layer output
- vals_clr  out  1  one-cycle pulse clearing MAC accumulators between layers
- result  out  row*datawidth  final output, valid with/after result_valid
- result_valid  out  1  one-cycle pulse when inference completes
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky watchdog flag (0 when TIMEOUT_EN undefined)

Behaviour:
- Reset (async, rst_vals high): state=IDLE; act_reg, result, layer_idx = 0; compute_start, layer_done, vals_clr, result_valid, busy, timeout_err = 0. Reset mid-operation abandons the layer immediately; no outputs complete.
- States: IDLE, ISSUE, WAIT_MAC, WAIT_TRUNC, DRAIN, NEXT, FINISH.
- IDLE: on start=1, act_reg<=in_vec, layer_idx<=0, go to ISSUE. start in any other state is ignored (not queued).
- ISSUE: compute_start=1 for exactly this cycle; go to WAIT_MAC.
- WAIT_MAC: hold until compute_done=1, then layer_done<=1 and go to WAIT_TRUNC. compute_done is ignored in all other states.
- WAIT_TRUNC: on trunc_done=1, act_reg<=layer_out_trunc, layer_done<=0, go to DRAIN.
- DRAIN: wait for trunc_done=0, so the truncation stage has returned to idle before the next layer_done.
  - If layer_idx==layers-1, go to FINISH.
  - Else go to NEXT.
- NEXT: vals_clr=1 for one cycle; layer_idx<=layer_idx+1; go to ISSUE.
- FINISH: result<=act_reg; result_valid=1 for one cycle; go to IDLE. result holds until the next FINISH or reset.
- Timing: minimum from start to compute_start = 1 cycle. Each inter-layer gap from trunc_done fall to next compute_start = 2 cycles. layers=1 skips NEXT entirely.
- layer_in = act_reg combinationally; stable from ISSUE through WAIT_TRUNC.
- compute_done and trunc_done high together in WAIT_MAC: only compute_done acts; trunc_done is evaluated next cycle in WAIT_TRUNC.
- layer_idx never wraps; it is reset to 0 only on accepted start.

Optional Feature:
- Macro: LAYER_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_MAC, WAIT_TRUNC or DRAIN and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES: timeout_err<=1 (sticky until reset), layer_done<=0, state<=IDLE, no result_valid.
- Undefined: no counter logic; timeout_err tied 0; waits are unbounded.

Test Plan (layers=2, row=4, datawidth=11):
- Nominal: in_vec={11'h001,11'h002,11'h003,11'h004}, start pulse; MAC model answers compute_done after 5 cycles; truncation model returns trunc_done after row+1 cycles with layer_out_trunc=input+1 → two compute_start pulses, one vals_clr between them, layer_idx 0 then 1, result={003,004,005,006}, one result_valid pulse, busy low afterwards.
- start held high through whole run and re-pulsed while busy → exactly one inference; second start accepted only after return to IDLE.
- trunc_done held high 3 cycles after layer_done falls → scheduler stays in DRAIN; next compute_start 2 cycles after trunc_done falls.
- rst_vals asserted in WAIT_TRUNC → layer_done, busy, layer_idx = 0 same cycle; no result_valid; a new start then completes normally.
- layers=1 build → one compute_start, no vals_clr, result_valid 1 cycle after DRAIN exit.
- LAYER_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, compute_done never asserted → timeout_err=1 after 16 cycles in WAIT_MAC, state IDLE, no result_valid; timeout_err stays 1 until rst_vals.
